arith_core_seq: RTL and testbench
=================================

// Module: arith_core_seq
// PURPOSE
// - Registered arithmetic core for the CPU datapath ALU.
// - Provides three operations:
//   - bitwise AND;
//   - 32-bit carry-lookahead add;
//   - signed radix-2 Booth multiply, run sequentially over DATA_WIDTH clocks.
// - Results are returned as a ZHigh/ZLow pair so they map directly onto the Z register.
// PARAMETERS
// DATA_WIDTH  32  operand width; must be a multiple of 4 (4-bit CLA groups)
// PORTS
// clk       in   1             rising-edge clock
// rst_n     in   1             asynchronous active-low reset
// start     in   1             request; sampled on a rising edge when busy=0
// op        in   2             00=AND, 01=ADD, 10=MUL, 11=reserved
// A         in   DATA_WIDTH    operand A (MUL: signed multiplicand)
// B         in   DATA_WIDTH    operand B (MUL: signed multiplier)
// cin       in   1             ADD carry-in; ignored for other ops
// busy      out  1             high while a MUL is iterating
// done      out  1             one-cycle pulse: ZHigh/ZLow/cout just updated
// ZHigh     out  DATA_WIDTH    upper result word
// ZLow      out  DATA_WIDTH    lower result word
// cout      out  1             ADD carry-out; 0 for other ops
// BEHAVIOUR
// - Reset (rst_n=0, async): busy, done, cout, ZHigh, ZLow and all internal state go to 0.
// - Reset mid-MUL aborts the operation; no done pulse follows.
// - Operands (A, B, op, cin) are captured only at the accepting edge. Later changes do not affect the op in flight.
// - start while busy=1 is ignored: no queueing, no effect on the running MUL.
// - AND, accepted at edge E0:
//   - ZLow=A&B, ZHigh=0, cout=0 registered at E0;
//   - done=1 for the cycle after E0.
// - ADD, accepted at edge E0:
//   - {cout,ZLow} = A+B+cin, modulo 2^DATA_WIDTH with carry-out; ZHigh=0;
//   - registered at E0; done=1 for one cycle.
//   - Adder is built from 4-bit lookahead groups (g=a&b, p=a^b) with group G/P and a second lookahead level across groups. No full ripple chain.
// - MUL, accepted at edge E0:
//   - E0: acc=0 (DATA_WIDTH+1 bits), Q=B, q_1=0, M=sign-extended A, counter=0, busy=1.
//   - Each subsequent edge Ek, k=1..DATA_WIDTH, is one iteration:
//     - {Q0,q_1}=01: acc+=M;
//     - {Q0,q_1}=10: acc-=M;
//     - 00/11: no add;
//     - then arithmetic right shift of {acc,Q,q_1} by 1.
//   - At E_DATA_WIDTH: {ZHigh,ZLow} = {acc[DATA_WIDTH-1:0],Q}, the exact signed 2*DATA_WIDTH product; cout=0; busy=0; done=1 for one cycle.
//   - Total latency is DATA_WIDTH+1 edges including acceptance.
//   - acc is DATA_WIDTH+1 bits so M=-2^(DATA_WIDTH-1) does not overflow.
// - Reserved op 11: ZHigh=ZLow=0, cout=0, done pulses one cycle after acceptance.
// - Outputs hold their last value between completions. done is never high while busy=1.
// - A new op may be accepted on the same edge that done is asserted for the previous AND/ADD.
//   - After a MUL, busy is already 0 on the done edge, so a start in the done cycle is accepted.
// TESTING
// - Reset: assert rst_n=0 mid-cycle -> busy=done=cout=0 and ZHigh=ZLow=0 immediately, with no clock needed.
// - AND: A=F0F0F0F0, B=0FF00FF0 -> ZLow=00F000F0, ZHigh=0, done one cycle after start.
// - ADD:
//   - FFFFFFFF+00000001, cin=0 -> ZLow=0, cout=1;
//   - 7FFFFFFF+1 -> ZLow=80000000, cout=0;
//   - 0+0, cin=1 -> ZLow=1.
// - MUL (-3)*7:
//   - A=FFFFFFFD, B=7 -> after 32 iterations ZHigh=FFFFFFFF, ZLow=FFFFFFEB, done pulsed once;
//   - 80000000*80000000 -> ZHigh=40000000, ZLow=0.
// - Protocol:
//   - start with op=AND while MUL busy -> ignored; MUL result unchanged;
//   - rst_n=0 at iteration 10 -> busy=0, outputs 0, no done.

Source files
------------

// File: rtl/arith_core_seq_if.sv
// Request/response bundle for arith_core_seq: operands and op in, Z pair and status out.
interface arith_core_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] ZHigh;
  logic [DATA_WIDTH-1:0] ZLow;
  logic                  cout;

  modport master (
    output start, op, A, B, cin,
    input  busy, done, ZHigh, ZLow, cout
  );

  modport slave (
    input  start, op, A, B, cin,
    output busy, done, ZHigh, ZLow, cout
  );
endinterface

// File: rtl/arith_core_seq.sv
// Registered ALU core: single-cycle AND and two-level carry-lookahead ADD,
// plus a sequential signed radix-2 Booth multiply producing a ZHigh/ZLow pair.
module arith_core_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  arith_core_seq_if.slave  bus
);
  localparam int NG = DATA_WIDTH / 4;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cout_q;
  logic [DATA_WIDTH-1:0] zhigh_q;
  logic [DATA_WIDTH-1:0] zlow_q;
  logic [DATA_WIDTH:0]   acc_q;
  logic [DATA_WIDTH:0]   m_q;
  logic [DATA_WIDTH-1:0] mq_q;
  logic                  q1_q;
  logic [CW-1:0]         cnt_q;

  // ---------------------------------------------------------------- adder
  logic [DATA_WIDTH-1:0] add_g;
  logic [DATA_WIDTH-1:0] add_p;
  logic [DATA_WIDTH-1:0] add_c;
  logic [DATA_WIDTH-1:0] add_sum;
  logic [NG-1:0]         grp_g;
  logic [NG-1:0]         grp_p;
  logic [NG:0]           grp_c;

  assign add_g = bus.A & bus.B;
  assign add_p = bus.A ^ bus.B;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int L = 4 * gi;
    logic [3:0] g;
    logic [3:0] p;
    logic       ci;

    assign g  = add_g[L+3:L];
    assign p  = add_p[L+3:L];
    assign ci = grp_c[gi];

    assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p[gi] = &p;

    assign add_c[L]   = ci;
    assign add_c[L+1] = g[0] | (p[0] & ci);
    assign add_c[L+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign add_c[L+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                      | (p[2] & p[1] & p[0] & ci);
  end

  // Group carries as flat sum-of-products over all lower groups.
  for (genvar gi = 0; gi <= NG; gi++) begin : g_look
    logic c_look;
    always_comb begin
      logic pp;
      c_look = 1'b0;
      pp     = 1'b1;
      for (int j = gi - 1; j >= 0; j--) begin
        c_look = c_look | (grp_g[j] & pp);
        pp     = pp & grp_p[j];
      end
      c_look = c_look | (bus.cin & pp);
    end
    assign grp_c[gi] = c_look;
  end

  assign add_sum = add_p ^ add_c;

  // ------------------------------------------------------- Booth iteration
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   acc_d;
  logic [DATA_WIDTH-1:0] mq_d;
  logic                  q1_d;

  always_comb begin
    unique case ({mq_q[0], q1_q})
      2'b01:   mul_sum = acc_q + m_q;
      2'b10:   mul_sum = acc_q - m_q;
      default: mul_sum = acc_q;
    endcase
    acc_d = {mul_sum[DATA_WIDTH], mul_sum[DATA_WIDTH:1]};
    mq_d  = {mul_sum[0], mq_q[DATA_WIDTH-1:1]};
    q1_d  = mq_q[0];
  end

  // ------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      zhigh_q <= '0;
      zlow_q  <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            unique case (bus.op)
              OP_AND: begin
                zlow_q  <= bus.A & bus.B;
                zhigh_q <= '0;
                cout_q  <= 1'b0;
                done_q  <= 1'b1;
              end
              OP_ADD: begin
                zlow_q  <= add_sum;
                zhigh_q <= '0;
                cout_q  <= grp_c[NG];
                done_q  <= 1'b1;
              end
              OP_MUL: begin
                acc_q   <= '0;
                m_q     <= {bus.A[DATA_WIDTH-1], bus.A};
                mq_q    <= bus.B;
                q1_q    <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_MUL;
              end
              default: begin
                zlow_q  <= '0;
                zhigh_q <= '0;
                cout_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          q1_q  <= q1_d;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            zhigh_q <= acc_d[DATA_WIDTH-1:0];
            zlow_q  <= mq_d;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.cout  = cout_q;
  assign bus.ZHigh = zhigh_q;
  assign bus.ZLow  = zlow_q;
endmodule

// File: tb/tb_arith_core_seq.sv
// Scoreboard bench for arith_core_seq: expected results queued at issue, checked on done.
module tb_arith_core_seq;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  arith_core_seq_if #(.DATA_WIDTH(DW)) bus();

  arith_core_seq #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [64:0] val;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) check("idle_timeout", 65'(bus.busy), 65'd0);
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ci);
    exp_t x;
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic [32:0] s;
    wait_idle();
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.cin   = ci;
    bus.start = 1'b1;
    x.tag = tag;
    x.due = cyc + 1;
    case (op)
      2'b00: x.val = {1'b0, 32'd0, a & b};
      2'b01: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        x.val = {s[32], 32'd0, s[31:0]};
      end
      2'b10: begin
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        x.val = {1'b0, sa * sbv};
        x.due = cyc + 1 + DW;
      end
      default: x.val = 65'd0;
    endcase
    sb.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 65'(bus.done), 65'd0);
      end else begin
        e = sb.pop_front();
        $display("txn %s: z=%h_%h cout=%b cyc=%0d", e.tag, bus.ZHigh, bus.ZLow, bus.cout, cyc);
        check({e.tag, "_val"}, {bus.cout, bus.ZHigh, bus.ZLow}, e.val);
        check({e.tag, "_lat"}, 65'(cyc), 65'(e.due));
        check("done_busy", 65'(bus.busy), 65'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.A = '0;
    bus.B = '0;
    bus.cin = 1'b0;

    // asynchronous reset mid-cycle, observed without a clock edge
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  65'(bus.busy),  65'd0);
    check("rst_done",  65'(bus.done),  65'd0);
    check("rst_cout",  65'(bus.cout),  65'd0);
    check("rst_zhigh", 65'(bus.ZHigh), 65'd0);
    check("rst_zlow",  65'(bus.ZLow),  65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue("and",     2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1);
    issue("add_wrap",2'b01, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    issue("add_ovf", 2'b01, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    issue("add_cin", 2'b01, 32'h00000000, 32'h00000000, 1'b1);
    issue("add_full",2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue("rsvd",    2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b1);

    // MUL with operand changes and an ignored start while busy
    issue("mul_m3x7", 2'b10, 32'hFFFFFFFD, 32'h00000007, 1'b0);
    repeat (5) @(negedge clk);
    bus.op = 2'b00;
    bus.A = 32'hDEADBEEF;
    bus.B = 32'h55555555;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    // accepted in the MUL done cycle
    issue("mul_min", 2'b10, 32'h80000000, 32'h80000000, 1'b0);
    issue("and_after", 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0);

    // reset at iteration 10 aborts the multiply with no done
    issue("mul_abort", 2'b10, 32'h00001234, 32'h00005678, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy",  65'(bus.busy),  65'd0);
    check("abort_zhigh", 65'(bus.ZHigh), 65'd0);
    check("abort_zlow",  65'(bus.ZLow),  65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), $urandom, $urandom,
            1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_empty", 65'(sb.size()), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
